game_ctrl: RTL and testbench

Frame-synchronous game sequencer for the VGA Flappy Bird design. It sits between the player inputs, the 640x480 timing/render datapath and the score display. It owns the game state machine and emits one update strobe per N frames to advance the bird and pillars. It also schedules pseudo-random pillar gap heights and keeps the BCD score and high score.

---
 rtl/game_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_game_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: frame-synchronous sequencer for VGA Flappy Bird (game FSM, step cadence, gap heights, BCD score).
// Optional high-score register is built only when the HISCORE_EN macro is defined.
`timescale 1ns/1ps
module game_ctrl #(
  parameter int unsigned FRAME_DIV   = 1,
  parameter int unsigned HOLD_FRAMES = 120,
  parameter int unsigned GAP_MIN     = 50,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        dclk,
  input  logic        clr_n,
  input  logic        vsync,
  input  logic        flap,
  input  logic        pause,
  input  logic        collide,
  input  logic        pass,
  input  logic        pillar_wrap,
  output logic [1:0]  state,
  output logic        step,
  output logic        flap_ev,
  output logic [9:0]  gap_y,
  output logic [15:0] score,
  output logic [15:0] hiscore
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  localparam logic [3:0] DIV_LAST  = 4'(FRAME_DIV - 1);
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);
  localparam logic [9:0] GAP_BASE  = 10'(GAP_MIN);

  // Galois form of x^8+x^6+x^5+x^4+1, shifting towards bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic [7:0] r;
    r = {1'b0, v[7:1]};
    if (v[0]) r = r ^ 8'hB8;
    else      r = r;
    return r;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v == 16'h9999) begin
      r = v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (c && (r[i*4 +: 4] == 4'd9)) r[i*4 +: 4] = 4'd0;
        else if (c) begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end else r[i*4 +: 4] = r[i*4 +: 4];
      end
    end
    return r;
  endfunction

  logic        vs_s1_q, vs_s2_q, vs_s3_q;
  logic        fl_s1_q, fl_s2_q, fl_smp_q;
  logic        pa_s1_q, pa_s2_q;
  logic        frame_tick_s, flap_rise_s;
  logic [7:0]  lfsr_nxt_s;

  state_e      state_q, state_d;
  logic [3:0]  div_q, div_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [9:0]  gap_y_q, gap_y_d;
  logic [15:0] score_q, score_d;
  logic        step_q, step_d;
  logic        flap_ev_q, flap_ev_d;

  assign frame_tick_s = vs_s3_q & ~vs_s2_q;
  // The button only counts as pressed if it was released at the previous frame sample
  assign flap_rise_s  = frame_tick_s & fl_s2_q & ~fl_smp_q;
  assign lfsr_nxt_s   = lfsr_next(lfsr_q);

  // Input synchronizers, vsync edge register and per-frame flap sample
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      vs_s1_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      vs_s3_q  <= 1'b0;
      fl_s1_q  <= 1'b0;
      fl_s2_q  <= 1'b0;
      fl_smp_q <= 1'b0;
      pa_s1_q  <= 1'b0;
      pa_s2_q  <= 1'b0;
    end else begin
      vs_s1_q  <= vsync;
      vs_s2_q  <= vs_s1_q;
      vs_s3_q  <= vs_s2_q;
      fl_s1_q  <= flap;
      fl_s2_q  <= fl_s1_q;
      fl_smp_q <= frame_tick_s ? fl_s2_q : fl_smp_q;
      pa_s1_q  <= pause;
      pa_s2_q  <= pa_s1_q;
    end
  end

  // Game FSM next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    hold_d    = hold_q;
    lfsr_d    = lfsr_q;
    gap_y_d   = gap_y_q;
    score_d   = score_q;
    step_d    = 1'b0;
    flap_ev_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flap_rise_s) begin
          state_d = S_PLAY;
          score_d = 16'h0000;
          div_d   = 4'd0;
          gap_y_d = GAP_BASE + {2'b00, lfsr_q};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        if (collide) begin
          state_d = S_OVER;
          hold_d  = HOLD_INIT;
        end else if (pa_s2_q) begin
          state_d = S_PAUSE;
        end else begin
          flap_ev_d = flap_rise_s;
          if (frame_tick_s && (div_q == DIV_LAST)) begin
            step_d = 1'b1;
            div_d  = 4'd0;
          end else if (frame_tick_s) begin
            div_d = div_q + 4'd1;
          end else begin
            div_d = div_q;
          end
          if (pass) score_d = bcd_inc(score_q);
          else      score_d = score_q;
          if (pillar_wrap) begin
            lfsr_d  = lfsr_nxt_s;
            gap_y_d = GAP_BASE + {2'b00, lfsr_nxt_s};
          end else begin
            lfsr_d  = lfsr_q;
            gap_y_d = gap_y_q;
          end
        end
      end
      S_PAUSE: begin
        if (!pa_s2_q) state_d = S_PLAY;
        else          state_d = S_PAUSE;
      end
      S_OVER: begin
        if (frame_tick_s) begin
          hold_d = hold_q - 8'd1;
          if (hold_q <= 8'd1) state_d = S_IDLE;
          else                state_d = S_OVER;
        end else begin
          hold_d = hold_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Game state and registered outputs
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      div_q     <= 4'd0;
      hold_q    <= 8'd0;
      lfsr_q    <= LFSR_SEED;
      gap_y_q   <= GAP_BASE + {2'b00, LFSR_SEED};
      score_q   <= 16'h0000;
      step_q    <= 1'b0;
      flap_ev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      hold_q    <= hold_d;
      lfsr_q    <= lfsr_d;
      gap_y_q   <= gap_y_d;
      score_q   <= score_d;
      step_q    <= step_d;
      flap_ev_q <= flap_ev_d;
    end
  end

`ifdef HISCORE_EN
  logic [15:0] hiscore_q, hiscore_d;

  // Capture the final score of a game when it beats the stored best (BCD orders like binary)
  always_comb begin
    hiscore_d = hiscore_q;
    if ((state_q == S_PLAY) && collide && (score_q > hiscore_q)) hiscore_d = score_q;
    else                                                          hiscore_d = hiscore_q;
  end

  // High-score register, kept across games
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) hiscore_q <= 16'h0000;
    else        hiscore_q <= hiscore_d;
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = 16'h0000;
`endif

  assign state   = state_q;
  assign step    = step_q;
  assign flap_ev = flap_ev_q;
  assign gap_y   = gap_y_q;
  assign score   = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: frame-level reference model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_game_ctrl;
  localparam int FD     = 2;
  localparam int HOLD   = 120;
  localparam int GAPMIN = 50;
`ifdef HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic dclk = 1'b0, clr_n = 1'b0, vsync = 1'b1, flap = 1'b0, pause = 1'b0;
  logic collide = 1'b0, pass = 1'b0, pillar_wrap = 1'b0;
  logic [1:0]  state;
  logic        step, flap_ev;
  logic [9:0]  gap_y;
  logic [15:0] score, hiscore;

  int n_err = 0, n_chk = 0;
  int step_seen = 0, step_ontime = 0, fev_seen = 0;

  game_ctrl #(.FRAME_DIV(FD), .HOLD_FRAMES(HOLD), .GAP_MIN(GAPMIN), .LFSR_SEED(8'hA5)) dut (
    .dclk(dclk), .clr_n(clr_n), .vsync(vsync), .flap(flap), .pause(pause),
    .collide(collide), .pass(pass), .pillar_wrap(pillar_wrap),
    .state(state), .step(step), .flap_ev(flap_ev), .gap_y(gap_y),
    .score(score), .hiscore(hiscore)
  );

  always #20 dclk = ~dclk;

  // Reference model: pins delayed through 2-stage sync histories, score kept as a decimal integer
  typedef struct {
    bit [2:0]  vs;
    bit [1:0]  fl;
    bit        fsmp;
    bit [1:0]  pa;
    int        st;
    int        frames;
    int        hold;
    bit [7:0]  lfsr;
    int        score;
    int        hi;
    bit        step;
    bit        fev;
    int        gap;
  } mdl_t;

  mdl_t m;

  function automatic bit [7:0] poly_step(input bit [7:0] v);
    bit [7:0] r;
    bit       o;
    o = v[0];
    r = v >> 1;
    if (o) r = r ^ 8'hB8;
    return r;
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  function automatic mdl_t mreset();
    mdl_t r;
    r.vs = 3'b000; r.fl = 2'b00; r.fsmp = 1'b0; r.pa = 2'b00;
    r.st = 0; r.frames = 0; r.hold = 0; r.lfsr = 8'hA5;
    r.score = 0; r.hi = 0; r.step = 1'b0; r.fev = 1'b0; r.gap = GAPMIN + 165;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t c, input bit vs_p, input bit fl_p, input bit pa_p,
                                 input bit col, input bit ps, input bit wr);
    mdl_t n;
    bit   tick, rise;
    n    = c;
    tick = c.vs[2] && !c.vs[1];
    rise = tick && c.fl[1] && !c.fsmp;
    n.vs = {c.vs[1], c.vs[0], vs_p};
    n.fl = {c.fl[0], fl_p};
    n.pa = {c.pa[0], pa_p};
    if (tick) n.fsmp = c.fl[1];
    n.step = 1'b0;
    n.fev  = 1'b0;
    case (c.st)
      0: if (rise) begin
           n.st = 1; n.score = 0; n.frames = 0; n.gap = GAPMIN + int'(c.lfsr);
         end
      1: if (col) begin
           n.st = 3; n.hold = HOLD;
           if (HI_EN && c.score > c.hi) n.hi = c.score;
         end else if (c.pa[1]) begin
           n.st = 2;
         end else begin
           if (tick) begin
             n.frames = c.frames + 1;
             n.step   = (n.frames % FD) == 0;
           end
           n.fev = rise;
           if (ps && c.score < 9999) n.score = c.score + 1;
           if (wr) begin
             n.lfsr = poly_step(c.lfsr);
             n.gap  = GAPMIN + int'(n.lfsr);
           end
         end
      2: if (!c.pa[1]) n.st = 1;
      3: if (tick) begin
           n.hold = c.hold - 1;
           if (n.hold == 0) n.st = 0;
         end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  always @(posedge dclk or negedge clr_n) begin
    if (!clr_n) m <= mreset();
    else        m <= mstep(m, vsync, flap, pause, collide, pass, pillar_wrap);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge dclk) begin
    if (clr_n) begin
      chk("state",   int'(state),   m.st);
      chk("step",    int'(step),    int'(m.step));
      chk("flap_ev", int'(flap_ev), int'(m.fev));
      chk("gap_y",   int'(gap_y),   m.gap);
      chk("score",   int'(score),   to_bcd(m.score));
      chk("hiscore", int'(hiscore), to_bcd(m.hi));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge dclk);
      if (step)    step_seen++;
      if (flap_ev) fev_seen++;
    end
  endtask

  task automatic frame();
    vsync = 1'b0;
    cyc(3);
    if (step) step_ontime++;
    cyc(1);
    vsync = 1'b1;
    cyc(12);
  endtask

  task automatic pulse(input bit p, input bit w, input bit c);
    pass = p; pillar_wrap = w; collide = c;
    cyc(1);
    pass = 1'b0; pillar_wrap = 1'b0; collide = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge dclk);
    chk("rst_state", int'(state), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_flap_ev", int'(flap_ev), 0);
    chk("rst_gap_y", int'(gap_y), 215);
    chk("rst_score", int'(score), 0);
    chk("rst_hiscore", int'(hiscore), 0);
    clr_n = 1'b1;
    cyc(4);

    // Game 1 start: transition lands one cycle after the frame tick
    flap = 1'b1;
    cyc(2);
    fev_seen = 0;
    vsync = 1'b0;
    cyc(2);
    chk("start_still_idle", int'(state), 0);
    cyc(1);
    chk("start_play", int'(state), 1);
    chk("start_gap_y", int'(gap_y), 215);
    chk("start_score", int'(score), 0);
    cyc(1);
    vsync = 1'b1;
    cyc(12);
    chk("start_no_flap_ev", fev_seen, 0);
    flap = 1'b0;

    step_seen = 0; step_ontime = 0;
    repeat (6) frame();
    chk("step_count", step_seen, 3);
    chk("step_latency", step_ontime, 3);

    flap = 1'b1;
    cyc(2);
    fev_seen = 0;
    frame();
    chk("flap_ev_count", fev_seen, 1);
    flap = 1'b0;
    cyc(2);
    frame();

    // Gap sequence from seed A5: EA, 75, 82
    pulse(1'b0, 1'b1, 1'b0);
    chk("gap_wrap1", int'(gap_y), 284);
    pulse(1'b0, 1'b1, 1'b0);
    chk("gap_wrap2", int'(gap_y), 167);
    pulse(1'b1, 1'b1, 1'b0);
    chk("gap_wrap3", int'(gap_y), 180);
    chk("pass_with_wrap", int'(score), 16'h0001);
    repeat (4) pulse(1'b1, 1'b0, 1'b0);
    chk("score5", int'(score), 16'h0005);

    pause = 1'b1;
    cyc(5);
    chk("pause_enter", int'(state), 2);
    step_seen = 0;
    for (int i = 0; i < 10; i++) begin
      frame();
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
    end
    chk("pause_no_step", step_seen, 0);
    chk("pause_score", int'(score), 16'h0005);
    chk("pause_gap_y", int'(gap_y), 180);
    pause = 1'b0;
    cyc(5);
    chk("pause_exit", int'(state), 1);

    pulse(1'b1, 1'b0, 1'b1);
    chk("collide_over", int'(state), 3);
    chk("collide_score", int'(score), 16'h0005);
    cyc(1);
    chk("hiscore_g1", int'(hiscore), HI_EN ? 16'h0005 : 0);
    repeat (HOLD - 1) frame();
    chk("hold_still_over", int'(state), 3);
    frame();
    chk("hold_done_idle", int'(state), 0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("idle_pass_ignored", int'(score), 16'h0005);

    // Game 2: LFSR carries over from game 1
    flap = 1'b1;
    cyc(2);
    frame();
    flap = 1'b0;
    chk("g2_play", int'(state), 1);
    chk("g2_gap_y", int'(gap_y), 180);
    chk("g2_score", int'(score), 0);
    repeat (12) pulse(1'b1, 1'b0, 1'b0);
    chk("score12", int'(score), 16'h0012);
    repeat (9987) pulse(1'b1, 1'b0, 1'b0);
    chk("score9999", int'(score), 16'h9999);
    pulse(1'b1, 1'b0, 1'b0);
    chk("score_sat", int'(score), 16'h9999);
    pulse(1'b0, 1'b0, 1'b1);
    chk("g2_over", int'(state), 3);
    cyc(1);
    chk("hiscore_g2", int'(hiscore), HI_EN ? 16'h9999 : 0);
    repeat (3) frame();
    chk("g2_mid_hold", int'(state), 3);

    #5 clr_n = 1'b0;
    #0.5;
    chk("arst_state", int'(state), 0);
    chk("arst_score", int'(score), 0);
    chk("arst_gap_y", int'(gap_y), 215);
    chk("arst_hiscore", int'(hiscore), 0);
    #0.5 clr_n = 1'b1;
    cyc(4);
    frame();
    chk("post_rst_idle", int'(state), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
